// File: rtl/seq_burst_arbiter_pkg.sv
// Shared constants for the sequence burst arbiter: table geometry, default
// sequence contents and the controller state encoding.
package seq_pkg;

  localparam int SEQ_DEPTH  = 8;
  localparam int SEQ_PTR_W  = 3;
  localparam int SEQ_DATA_W = 8;

  // Entry 0 sits in the least-significant byte.
  localparam logic [SEQ_DEPTH-1:0][SEQ_DATA_W-1:0] SEQ_DEFAULT = {
    8'h8D, 8'h0B, 8'hE2, 8'hFF, 8'h78, 8'hE2, 8'hBC, 8'hAF
  };

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    STREAM
  } seq_state_t;

endpackage

// File: rtl/seq_burst_arbiter_if.sv
// Request/grant and valid/ready stream bundle between the clients and the
// sequence burst arbiter; the arbiter takes the master side.
interface seq_burst_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 4
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*LEN_W-1:0] req_len;
  logic [NUM_REQ-1:0]       grant;
  logic                     out_valid;
  logic                     out_ready;
  logic [7:0]               out_data;
  logic                     out_last;
  logic [ID_W-1:0]          out_id;
  logic                     busy;

  modport master (
    input  req, req_len, out_ready,
    output grant, out_valid, out_data, out_last, out_id, busy
  );

  modport slave (
    output req, req_len, out_ready,
    input  grant, out_valid, out_data, out_last, out_id, busy
  );

endinterface

// File: rtl/seq_burst_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first set request at or above rr, wrapping
// modulo NUM_REQ; returns a one-hot grant and an any-request flag.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr,
  output logic [NUM_REQ-1:0] gnt,
  output logic               valid
);

  logic found;
  int   idx;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = (int'(rr) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/seq_burst_arbiter.sv
// Arbitrated burst source over a shared 8-entry byte sequence table with
// per-client read positions. SEQ_TABLE_WR_EN makes the table writable.
module seq_burst_arbiter
  import seq_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
`ifdef SEQ_TABLE_WR_EN
  input  logic                 tbl_wr_en,
  input  logic [SEQ_PTR_W-1:0] tbl_wr_addr,
  input  logic [7:0]           tbl_wr_data,
`endif
  seq_burst_arbiter_if.master  bus
);

  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  seq_state_t                       state, state_nxt;
  logic [ID_W-1:0]                  id, pick_id, rr, next_rr;
  logic [LEN_W-1:0]                 remaining;
  logic [SEQ_PTR_W-1:0]             ptr;
  logic [SEQ_PTR_W-1:0]             pos [NUM_REQ];
  logic [NUM_REQ-1:0]               pick_oh;
  logic                             pick_vld;
  logic [7:0]                       out_data;
  logic                             out_valid, out_last;
  logic                             accept, latch, load_first, advance, finish;
  logic [SEQ_DEPTH-1:0][7:0]        tbl;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req   (bus.req),
    .rr    (rr),
    .gnt   (pick_oh),
    .valid (pick_vld)
  );

  always_comb begin
    pick_id = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick_oh[i]) pick_id = ID_W'(i);
  end

`ifdef SEQ_TABLE_WR_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         tbl <= SEQ_DEFAULT;
    else if (tbl_wr_en) tbl[tbl_wr_addr] <= tbl_wr_data;
  end
`else
  assign tbl = SEQ_DEFAULT;
`endif

  assign accept  = out_valid & bus.out_ready;
  assign next_rr = (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    latch      = 1'b0;
    load_first = 1'b0;
    advance    = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: if (pick_vld) begin
        latch     = 1'b1;
        state_nxt = GRANT;
      end
      GRANT: begin
        load_first = 1'b1;
        state_nxt  = STREAM;
      end
      STREAM: if (accept) begin
        if (out_last) begin
          finish    = 1'b1;
          state_nxt = IDLE;
        end else begin
          advance = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Next beat is loaded on the accepting edge so a held-ready stream has no bubble.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id        <= '0;
      rr        <= '0;
      remaining <= '0;
      ptr       <= '0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++) pos[i] <= '0;
    end else begin
      if (latch) begin
        id        <= pick_id;
        remaining <= bus.req_len[pick_id*LEN_W +: LEN_W];
        ptr       <= pos[pick_id];
      end
      if (load_first) begin
        out_valid <= 1'b1;
        out_data  <= tbl[ptr];
        out_last  <= (remaining == '0);
      end
      if (advance) begin
        ptr       <= ptr + 1'b1;
        remaining <= remaining - 1'b1;
        out_data  <= tbl[ptr + 1'b1];
        out_last  <= (remaining == LEN_W'(1));
      end
      if (finish) begin
        pos[id]   <= ptr + 1'b1;
        rr        <= next_rr;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

  assign bus.grant     = (state != IDLE) ? (NUM_REQ'(1) << id) : '0;
  assign bus.out_id    = id;
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid;
  assign bus.out_data  = out_data;
  assign bus.out_last  = out_last;

endmodule

// File: tb/tb_seq_burst_arbiter.sv
// Directed bench for seq_burst_arbiter; covers table writes when built with
// SEQ_TABLE_WR_EN and the constant table otherwise.
module tb_seq_burst_arbiter;
  import seq_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  seq_burst_arbiter_if #(.NUM_REQ(4), .LEN_W(4)) bus ();

`ifdef SEQ_TABLE_WR_EN
  logic       tbl_wr_en   = 1'b0;
  logic [2:0] tbl_wr_addr = 3'd0;
  logic [7:0] tbl_wr_data = 8'h00;
`endif

  seq_burst_arbiter #(.NUM_REQ(4), .LEN_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
`ifdef SEQ_TABLE_WR_EN
    .tbl_wr_en   (tbl_wr_en),
    .tbl_wr_addr (tbl_wr_addr),
    .tbl_wr_data (tbl_wr_data),
`endif
    .bus         (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_grant"}, 32'(bus.grant), 32'h0);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'h0);
    chk({tag, "_busy"},  32'(bus.busy), 32'h0);
  endtask

  task automatic do_reset();
    bus.req   = '0;
    bus.out_ready = 1'b1;
    reset = 1'b0;
    #2;
    chk_idle("rst");
    chk("rst_data", 32'(bus.out_data), 32'h00);
    chk("rst_last", 32'(bus.out_last), 32'h0);
    chk("rst_id",   32'(bus.out_id),   32'h0);
    reset = 1'b1;
  endtask

  task automatic set_req(input int r, input int len);
    bus.req[r] = 1'b1;
    bus.req_len[r*4 +: 4] = 4'(len);
  endtask

  task automatic await_grant(input int r);
    tick();
    chk($sformatf("grant_r%0d", r), 32'(bus.grant), 32'(1) << r);
    chk($sformatf("id_r%0d", r),    32'(bus.out_id), 32'(r));
    chk($sformatf("busy_r%0d", r),  32'(bus.busy), 32'h1);
    chk($sformatf("novalid_r%0d", r), 32'(bus.out_valid), 32'h0);
  endtask

  // Streams exp_q; with stall set, odd beats see out_ready low for 2 cycles.
  task automatic stream(input string tag, input bit stall);
    int n;
    n = exp_q.size();
    tick();
    for (int b = 0; b < n; b++) begin
      chk($sformatf("%s_valid%0d", tag, b), 32'(bus.out_valid), 32'h1);
      chk($sformatf("%s_data%0d", tag, b),  32'(bus.out_data), 32'(exp_q[b]));
      chk($sformatf("%s_last%0d", tag, b),  32'(bus.out_last), 32'(b == n - 1));
      if (stall && (b % 2 == 1)) begin
        bus.out_ready = 1'b0;
        repeat (2) begin
          tick();
          chk($sformatf("%s_hold%0d", tag, b),  32'(bus.out_data), 32'(exp_q[b]));
          chk($sformatf("%s_hvld%0d", tag, b),  32'(bus.out_valid), 32'h1);
        end
        bus.out_ready = 1'b1;
      end
      tick();
    end
    chk_idle({tag, "_end"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req       = '0;
    bus.req_len   = '0;
    bus.out_ready = 1'b1;
    #12;
    do_reset();
    tick();

    // Single client, consecutive bursts continue from its saved position.
    set_req(0, 2);
    await_grant(0);
    bus.req[0] = 1'b0;
    exp_q = '{8'hAF, 8'hBC, 8'hE2};
    stream("r0a", 1'b0);
    set_req(0, 0);
    await_grant(0);
    bus.req[0] = 1'b0;
    exp_q = '{8'h78};
    stream("r0b", 1'b0);

    // Two contending clients alternate; each keeps its own position.
    do_reset();
    tick();
    set_req(0, 1);
    set_req(1, 1);
    await_grant(0);
    bus.req[0] = 1'b0;
    exp_q = '{8'hAF, 8'hBC};
    stream("p0a", 1'b0);
    await_grant(1);
    bus.req[1] = 1'b0;
    stream("p1a", 1'b0);
    set_req(0, 1);
    set_req(1, 1);
    await_grant(0);
    bus.req[0] = 1'b0;
    exp_q = '{8'hE2, 8'h78};
    stream("p0b", 1'b0);
    await_grant(1);
    bus.req[1] = 1'b0;
    stream("p1b", 1'b0);

    // Long burst wraps the table, with backpressure stalls.
    do_reset();
    tick();
    set_req(2, 9);
    await_grant(2);
    bus.req[2] = 1'b0;
    exp_q = '{8'hAF, 8'hBC, 8'hE2, 8'h78, 8'hFF, 8'hE2, 8'h0B, 8'h8D, 8'hAF, 8'hBC};
    stream("wrap", 1'b1);
    set_req(2, 0);
    await_grant(2);
    bus.req[2] = 1'b0;
    exp_q = '{8'hE2};
    stream("wrap_pos", 1'b0);

    // Reset in the middle of a burst drops it without a position update.
    do_reset();
    tick();
    set_req(3, 3);
    await_grant(3);
    bus.req[3] = 1'b0;
    tick();
    chk("mid_b0", 32'(bus.out_data), 32'hAF);
    tick();
    chk("mid_b1", 32'(bus.out_data), 32'hBC);
    chk("mid_v1", 32'(bus.out_valid), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    chk_idle("mid_rst");
    chk("mid_rst_data", 32'(bus.out_data), 32'h00);
    #1;
    reset = 1'b1;
    tick();
    set_req(3, 0);
    await_grant(3);
    bus.req[3] = 1'b0;
    exp_q = '{8'hAF};
    stream("after_rst", 1'b0);

    // Table entry 0 seen by a fresh client.
    do_reset();
    tick();
`ifdef SEQ_TABLE_WR_EN
    tbl_wr_en   = 1'b1;
    tbl_wr_addr = 3'd0;
    tbl_wr_data = 8'h5A;
    tick();
    tbl_wr_en   = 1'b0;
    set_req(3, 0);
    await_grant(3);
    bus.req[3] = 1'b0;
    exp_q = '{8'h5A};
    stream("tbl_wr", 1'b0);
`else
    set_req(3, 0);
    await_grant(3);
    bus.req[3] = 1'b0;
    exp_q = '{8'hAF};
    stream("tbl_const", 1'b0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
